// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_pkg: shared FSM state encoding, register-zero constant and load-use hazard detect helper
package pipeline_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_MEM_WAIT = 2'd1, ST_ERROR = 2'd2} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic load_use(input logic mrd, input logic [4:0] dst, rs, rt, input logic urs, urt);
    return mrd & (dst != REG_ZERO) & ((urs & (dst == rs)) | (urt & (dst == rt)));
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard bus; master = pipeline (ID/EX/MEM status in, enables/flushes/stats out), slave = controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic [4:0] idRs, idRt, exRegDest;
  logic idUsesRs, idUsesRt, exMemRead, exBranchTaken, exJump, memReq, memReady;
  logic pcWriteEnable, ifIdEnable, idExEnable, exMemEnable, ifIdFlush, idExFlush, memTimeoutErr;
  logic [CNT_WIDTH-1:0] stallCount, flushCount;
  modport master(
    output idRs, idRt, exRegDest, idUsesRs, idUsesRt, exMemRead, exBranchTaken, exJump, memReq, memReady,
    input pcWriteEnable, ifIdEnable, idExEnable, exMemEnable, ifIdFlush, idExFlush, memTimeoutErr, stallCount, flushCount
  );
  modport slave(
    input idRs, idRt, exRegDest, idUsesRs, idUsesRt, exMemRead, exBranchTaken, exJump, memReq, memReady,
    output pcWriteEnable, ifIdEnable, idExEnable, exMemEnable, ifIdFlush, idExFlush, memTimeoutErr, stallCount, flushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: WIDTH-bit up counter (clk, rst_n sync active-low, inc) that holds at all-ones
module sat_counter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/redirect/mem-wait hazard controller (clk, rst_n, bus.slave) with mem watchdog and stall/flush stats
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT = WW'(MEM_TIMEOUT);
  state_t state_q;
  logic [WW-1:0] wait_q;
  logic err_q, mem_stall, redirect, lu, freeze, do_redirect, do_stall;
  assign mem_stall   = bus.memReq & ~bus.memReady;
  assign redirect    = bus.exBranchTaken | bus.exJump;
  assign lu          = load_use(bus.exMemRead, bus.exRegDest, bus.idRs, bus.idRt, bus.idUsesRs, bus.idUsesRt);
  assign freeze      = ~rst_n | (state_q == ST_ERROR) | mem_stall;
  assign do_redirect = ~freeze & redirect;
  assign do_stall    = ~freeze & ~redirect & lu;
  assign bus.pcWriteEnable = ~freeze & ~do_stall;
  assign bus.ifIdEnable    = ~freeze & ~do_stall;
  assign bus.idExEnable    = ~freeze;
  assign bus.exMemEnable   = ~freeze;
  assign bus.ifIdFlush     = do_redirect;
  assign bus.idExFlush     = do_redirect | do_stall;
  assign bus.memTimeoutErr = err_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else
      case (state_q)
        ST_RUN:
          if (mem_stall) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= WW'(1);
          end
        ST_MEM_WAIT:
          if (!mem_stall) state_q <= ST_RUN;
          else if (wait_q == TIMEOUT) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
          end else wait_q <= wait_q + 1'b1;
        ST_ERROR: ;
        default: state_q <= ST_RUN;
      endcase
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (.clk(clk), .rst_n(rst_n), .inc(do_stall), .count(bus.stallCount));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush (.clk(clk), .rst_n(rst_n), .inc(do_redirect), .count(bus.flushCount));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_WIDTH=3)
module tb_pipeline_hazard_ctrl;
  localparam logic [5:0] RUN = 6'b1111_00, FRZ = 6'b0000_00, RED = 6'b1111_11, LU = 6'b0011_01;
  typedef struct {
    logic rst;
    logic [4:0] rs, rt, dst;
    logic urs, urt, mrd, br, jmp, req, rdy;
    logic [5:0] outs;
    logic err;
  } vec_t;
  typedef struct {
    logic [5:0] outs;
    logic err;
    logic [2:0] sc, fc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int passed = 0, total = 0, idx = 0;
  logic [2:0] sc_m = 3'd0, fc_m = 3'd0;
  exp_t q[$];
  vec_t tbl[10];
  pipeline_hazard_ctrl_if #(.CNT_WIDTH(3)) bus();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic vec_t mkv(input logic rst, input logic [4:0] rs, rt, dst, input logic urs, urt, mrd, br, jmp, req, rdy,
                               input logic [5:0] outs, input logic err);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.dst = dst; v.urs = urs; v.urt = urt; v.mrd = mrd;
    v.br = br; v.jmp = jmp; v.req = req; v.rdy = rdy; v.outs = outs; v.err = err;
    return v;
  endfunction
  task automatic chk(input string n, input logic [7:0] got, want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s step%0d got %0h want %0h", n, idx, got, want);
  endtask
  task automatic apply(input vec_t v);
    exp_t e, g;
    @(posedge clk); #1;
    rst_n = v.rst; bus.idRs = v.rs; bus.idRt = v.rt; bus.exRegDest = v.dst; bus.idUsesRs = v.urs; bus.idUsesRt = v.urt;
    bus.exMemRead = v.mrd; bus.exBranchTaken = v.br; bus.exJump = v.jmp; bus.memReq = v.req; bus.memReady = v.rdy;
    e.outs = v.outs; e.err = v.err; e.sc = sc_m; e.fc = fc_m;
    q.push_back(e);
    if (!v.rst) begin
      sc_m = 3'd0;
      fc_m = 3'd0;
    end else begin
      if (v.outs == LU && sc_m != 3'd7) sc_m++;
      if (v.outs == RED && fc_m != 3'd7) fc_m++;
    end
    @(negedge clk);
    g = q.pop_front();
    chk("outs", {2'b0, bus.pcWriteEnable, bus.ifIdEnable, bus.idExEnable, bus.exMemEnable, bus.ifIdFlush, bus.idExFlush}, {2'b0, g.outs});
    chk("err", {7'b0, bus.memTimeoutErr}, {7'b0, g.err});
    chk("stallCount", {5'b0, bus.stallCount}, {5'b0, g.sc});
    chk("flushCount", {5'b0, bus.flushCount}, {5'b0, g.fc});
    idx++;
  endtask
  initial begin
    {bus.idRs, bus.idRt, bus.exRegDest} = '0;
    {bus.idUsesRs, bus.idUsesRt, bus.exMemRead, bus.exBranchTaken, bus.exJump, bus.memReq, bus.memReady} = '0;
    tbl[0] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
    tbl[1] = mkv(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, RUN, 0);
    tbl[2] = mkv(1, 5, 0, 5, 1, 0, 1, 1, 0, 0, 0, RED, 0);
    tbl[3] = mkv(1, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0, LU, 0);
    tbl[4] = mkv(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, RUN, 0);
    tbl[5] = mkv(1, 1, 7, 7, 0, 1, 1, 0, 0, 0, 0, LU, 0);
    tbl[6] = mkv(1, 1, 7, 7, 1, 0, 1, 0, 0, 0, 0, RUN, 0);
    tbl[7] = mkv(1, 9, 9, 9, 1, 1, 0, 0, 0, 0, 0, RUN, 0);
    tbl[8] = mkv(1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, RED, 0);
    tbl[9] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN, 0);
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0));
    foreach (tbl[i]) apply(tbl[i]);
    for (int i = 0; i < 3; i++) apply(mkv(1, 5, 0, 5, 1, 0, 1, i[0], 0, 1, 0, FRZ, 0));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN, 0));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0));
    for (int i = 0; i < 5; i++) apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 1));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 1));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 1));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0));
    for (int i = 0; i < 9; i++) apply(mkv(1, 4, 0, 4, 1, 0, 1, 0, 0, 0, 0, LU, 0));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0));
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC write enable. It detects load-use hazards, branch/jump redirects resolved in EX, and multi-cycle data-memory waits. It also keeps a memory-wait watchdog and saturating stall/flush statistics counters.

Parameters:
MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before the sticky timeout error sets
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  synchronous active-low reset
idRs  input  5  rs field of the instruction in ID
idRt  input  5  rt field of the instruction in ID
idUsesRs  input  1  ID instruction reads rs
idUsesRt  input  1  ID instruction reads rt
exMemRead  input  1  MemReadFlag of the instruction in EX (ID/EX output)
exRegDest  input  5  destination register of the instruction in EX
exBranchTaken  input  1  branch resolved taken in EX
exJump  input  1  jump in EX
memReq  input  1  MEM stage has an active data-memory access
memReady  input  1  data memory completes the access this cycle
pcWriteEnable  output  1  PC update enable
ifIdEnable  output  1  IF/ID register load enable
idExEnable  output  1  ID/EX register load enable (drives its controlSignal)
exMemEnable  output  1  EX/MEM register load enable
ifIdFlush  output  1  load a NOP into IF/ID
idExFlush  output  1  load a bubble (all control flags 0) into ID/EX
memTimeoutErr  output  1  sticky watchdog error
stallCount  output  CNT_WIDTH  load-use stall cycles, saturating
flushCount  output  CNT_WIDTH  redirect events, saturating

Behaviour:
- Definitions, all combinational:
  - loadUse = exMemRead & (exRegDest != 0) & ((idUsesRs & exRegDest == idRs) | (idUsesRt & exRegDest == idRt))
  - memStall = memReq & ~memReady
  - redirect = exBranchTaken | exJump
- States: RUN, MEM_WAIT, ERROR. The state register is 2 bits. The wait counter is the minimum width needed to hold MEM_TIMEOUT.
- Enable and flush outputs are combinational from the current state and inputs, so they take effect at the same edge. Priority, highest first:
  - rst_n = 0 or state ERROR: all enables 0, both flushes 0 (freeze).
  - memStall: all enables 0, flushes 0 (full freeze, no bubble).
  - redirect: all enables 1, ifIdFlush = 1, idExFlush = 1.
  - loadUse: pcWriteEnable = 0, ifIdEnable = 0, idExEnable = 1, idExFlush = 1, exMemEnable = 1, ifIdFlush = 0. This inserts one bubble; the hazard clears the next cycle because the load has moved to MEM.
  - otherwise: all enables 1, flushes 0.
- FSM transitions, evaluated at the clock edge:
  - RUN -> MEM_WAIT when memStall; the wait counter loads 1.
  - MEM_WAIT -> RUN when memReady.
  - MEM_WAIT stays in MEM_WAIT and increments the wait counter while memStall persists.
  - MEM_WAIT -> ERROR when memStall persists and the wait counter equals MEM_TIMEOUT.
  - ERROR is terminal until reset; memTimeoutErr = 1 in ERROR.
- Simultaneous events:
  - memStall together with redirect or loadUse: the freeze wins. The redirect or loadUse is not acted on or counted that cycle. The inputs are held by the frozen registers and re-evaluate on the release cycle.
  - redirect together with loadUse: the redirect wins, because the flush squashes the dependent instruction. Only flushCount increments.
- Counters:
  - stallCount increments by 1 in each cycle where the loadUse branch of the priority list is taken.
  - flushCount increments by 1 in each cycle where the redirect branch is taken.
  - Both saturate at all-ones with no wrap.
- Reset (rst_n low at a rising edge):
  - state = RUN, wait counter = 0, memTimeoutErr = 0, stallCount = 0, flushCount = 0.
  - Reset asserted mid-MEM_WAIT or in ERROR returns to RUN at the next edge.
  - While rst_n is low, the enable outputs read 0 and the flush outputs read 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state encoding constants ST_RUN = 0, ST_MEM_WAIT = 1, ST_ERROR = 2
  - the register-zero constant REG_ZERO = 5'd0
- One natural sub-module, sat_counter. It is parameterised by width, with inputs clk, rst_n and inc and a saturating count output. It is instantiated twice, for the stall and flush counters.

Test Plan:
- Load-use: exMemRead = 1, exRegDest = 5, idRs = 5, idUsesRs = 1, for one cycle -> pcWriteEnable = 0, ifIdEnable = 0, idExFlush = 1, idExEnable = 1; stallCount 0 -> 1; next cycle with exMemRead = 0, all enables 1.
- Register-zero guard: the same stimulus with exRegDest = 0 -> no stall, stallCount stays 0.
- Redirect: exBranchTaken = 1 together with a loadUse condition -> ifIdFlush = 1, idExFlush = 1, all enables 1; flushCount = 1, stallCount = 0.
- Memory wait: memReq = 1, memReady = 0 for 3 cycles, then memReady = 1 -> all enables 0 for 3 cycles; state returns to RUN; enables 1 on the release cycle; no error.
- Watchdog: MEM_TIMEOUT = 4, memReq = 1, memReady held 0 -> memTimeoutErr = 1 after the 5th stalled edge; outputs stay frozen; asserting rst_n = 0 for one edge clears the error and returns to RUN.
- Saturation: CNT_WIDTH = 3, force 9 load-use cycles -> stallCount holds 7.
